hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting beside the ID stage. It handles four cases:
- **Load-use hazards:** stalls for a configurable number of cycles, with x0 and unused-operand exclusion.
- **Taken-branch flushes** from EX.
- **Whole-pipeline freezes** while a data-memory access waits for `mem_ready`.
- **Performance counting:** a saturating count of lost fetch cycles.

All control outputs are Mealy-decoded from the registered state plus current inputs.

## Interface
- `REG_ADDR_W`, 5, register-index width.
- `LOAD_USE_STALL`, 1, bubbles inserted per load-use hazard, legal 1..7.
- `CNT_W`, 3, stall-counter width; must hold `LOAD_USE_STALL`.
- `PERF_W`, 32, width of the stall performance counter.

- `clk` in 1: clock, rising edge.
- `arst_n` in 1: asynchronous active-low reset.
- `id_ex_mem_read` in 1: instruction in EX is a load.
- `id_ex_rd` in `REG_ADDR_W`: destination of the instruction in EX.
- `if_id_rs1`, `if_id_rs2` in `REG_ADDR_W`: sources of the instruction in ID.
- `if_id_uses_rs1`, `if_id_uses_rs2` in 1: ID instruction actually reads rs1/rs2.
- `ex_branch_taken` in 1: branch/jump in EX resolved taken.
- `mem_req` in 1: MEM stage is issuing a data-memory access this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC may update.
- `if_id_write` out 1: IF/ID register may load.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_bubble` out 1: ID/EX loads a NOP (control bits zero).
- `pipe_freeze` out 1: ID/EX, EX/MEM and MEM/WB hold their contents.
- `stall_cycles` out `PERF_W`: saturating count of cycles with `pc_write`=0.

## Operation
- **Load-use hit (combinational).** Asserted when all of the following hold:
  - `id_ex_mem_read`=1;
  - `id_ex_rd`≠0;
  - `if_id_uses_rs1` && rs1==rd, or `if_id_uses_rs2` && rs2==rd.
- **Output profiles.**
  - Idle: `pc_write`=1, `if_id_write`=1, all other outputs 0.
  - Stall: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
  - Flush: `pc_write`=1, `if_id_flush`=1, `id_ex_bubble`=1.
  - Freeze: `pc_write`=0, `if_id_write`=0, `pipe_freeze`=1, bubble 0.
- **RUN state.** Priority is freeze > flush > stall > idle.
  - `mem_req` && !`mem_ready`: Freeze profile; go to MEM_WAIT with ret=RUN.
  - Else `ex_branch_taken`: Flush profile; stay in RUN. Any load-use hit is ignored because the ID instruction is wrong-path.
  - Else load-use hit: Stall profile. If `LOAD_USE_STALL`>1, load cnt=`LOAD_USE_STALL`-1 and go to LU_STALL; otherwise stay in RUN.
  - Else: Idle profile.
- **LU_STALL state.**
  - `mem_req` && !`mem_ready`: Freeze profile; cnt held; go to MEM_WAIT with ret=LU_STALL.
  - Otherwise: Stall profile and cnt decrements. When cnt==1, return to RUN next cycle.
  - Total bubbles per hazard equal `LOAD_USE_STALL` exactly.
  - `ex_branch_taken` in this state: Flush profile, cnt cleared, go to RUN. This cannot occur with legal inputs but must be handled.
- **MEM_WAIT state.**
  - Freeze profile while !`mem_ready`. `ex_branch_taken` and the load-use hit are ignored, because EX is frozen and re-presents them afterwards.
  - On `mem_ready`=1: this cycle uses the profile of ret evaluated with the memory condition false, and the same cycle transitions as ret would. A `LOAD_USE_STALL`=1 hit therefore stalls in that cycle, not a cycle later.
- **`stall_cycles`.** Increments every cycle `pc_write`=0 and saturates at all-ones. Flush cycles are not counted.
- **Reset.**
  - State=RUN, cnt=0, ret=RUN, `stall_cycles`=0.
  - While `arst_n`=0, outputs are forced to the Idle profile regardless of inputs.
  - Reset asserted mid-stall or mid-wait aborts immediately with no residual stall.

## Timing
- Detection-to-output latency is 0 cycles (combinational from registered state and inputs). State, cnt, ret and `stall_cycles` update on the rising edge of `clk`.
- A load-use hazard costs exactly `LOAD_USE_STALL` cycles plus any MEM_WAIT cycles that overlap it.
- A taken branch costs 2 flushed slots (IF/ID and ID/EX) in 1 cycle.
- `mem_req`=1 with `mem_ready`=1 in the same cycle causes no freeze.
- MEM_WAIT has no timeout; it waits indefinitely for `mem_ready`.

## Test plan
- **Load-use, default stall:** `LOAD_USE_STALL`=1, `id_ex_mem_read`=1, rd=5, rs1=5, uses_rs1=1 → one cycle with `pc_write`=0 and `id_ex_bubble`=1, then Idle; `stall_cycles`=1.
- **x0 and unused operand:**
  - rd=0, rs1=0 → no stall.
  - rd=7, rs2=7, uses_rs2=0 → no stall.
  - Non-load rd=7, rs1=7 → no stall.
- **Multi-cycle stall with freeze:** `LOAD_USE_STALL`=3, hit in cycle 0; `mem_req`=1, `mem_ready`=0 in cycles 1–2 → cycle 0 Stall, cycles 1–2 Freeze, cycles 3–4 Stall, cycle 5 Idle; `stall_cycles`=5.
- **Branch vs load-use:** hit plus `ex_branch_taken` in the same cycle → Flush profile (`pc_write`=1, `if_id_flush`=1, `id_ex_bubble`=1); no stall follows.
- **Memory wait vs branch:** `mem_req`=1, `mem_ready`=0 for 4 cycles with `ex_branch_taken`=1 → 4 Freeze cycles; flush occurs only in the cycle `mem_ready`=1.
- **Reset and saturation:**
  - `arst_n` low mid-LU_STALL (cnt=2) → outputs Idle immediately; after release, no stall.
  - `PERF_W`=4 with 20 stall cycles → `stall_cycles` holds 15.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-controller signal bundle.
// Groups the pipeline-side inputs (load in EX, operand indices, branch
// resolution, data-memory handshake) and the control outputs (PC/IF-ID write
// enables, flush/bubble/freeze strobes, stall performance counter).
//   master : pipeline side, drives the hazard inputs and observes the controls
//   slave  : hazard_unit side
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
);
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic                  if_id_uses_rs1;
    logic                  if_id_uses_rs2;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  pipe_freeze;
    logic [PERF_W-1:0]     stall_cycles;

    modport master (
        output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, ex_branch_taken,
               mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_cycles
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, ex_branch_taken,
               mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core, beside the ID stage.
// Handles load-use stalls (LOAD_USE_STALL bubbles), taken-branch flushes,
// whole-pipeline freezes while a data-memory access waits for mem_ready, and
// a saturating count of cycles in which the PC did not advance.
// Ports:
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset; outputs forced to Idle while low
//   hz     : hazard_unit_if.slave bundle (hazard inputs, control outputs)
// Control outputs are Mealy-decoded from the registered state plus inputs.
module hazard_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 3,
    parameter int PERF_W         = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
    typedef enum logic [1:0] {P_IDLE, P_STALL, P_FLUSH, P_FREEZE} profile_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_USE_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state, state_nx, ret, ret_nx, eval_state;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [PERF_W-1:0] perf_q;
    profile_t          prof;
    logic              lu_hit;
    logic              mem_block;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;

    assign rd  = hz.id_ex_rd;
    assign rs1 = hz.if_id_rs1;
    assign rs2 = hz.if_id_rs2;

    assign lu_hit = hz.id_ex_mem_read && (rd != '0) &&
                    ((hz.if_id_uses_rs1 && (rs1 == rd)) ||
                     (hz.if_id_uses_rs2 && (rs2 == rd)));

    // On mem_ready in MEM_WAIT the cycle is evaluated as the return state
    // with the memory condition masked, so a completing access and the
    // following stall/flush decision share one cycle.
    always_comb begin
        eval_state = state;
        mem_block  = hz.mem_req && !hz.mem_ready;
        if (state == MEM_WAIT && hz.mem_ready) begin
            eval_state = ret;
            mem_block  = 1'b0;
        end

        state_nx = eval_state;
        ret_nx   = ret;
        cnt_nx   = cnt;
        prof     = P_IDLE;

        case (eval_state)
            RUN: begin
                if (mem_block) begin
                    prof     = P_FREEZE;
                    state_nx = MEM_WAIT;
                    ret_nx   = RUN;
                end else if (hz.ex_branch_taken) begin
                    prof = P_FLUSH;
                end else if (lu_hit) begin
                    prof = P_STALL;
                    if (LOAD_USE_STALL > 1) begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (mem_block) begin
                    prof     = P_FREEZE;
                    state_nx = MEM_WAIT;
                    ret_nx   = LU_STALL;
                end else if (hz.ex_branch_taken) begin
                    prof     = P_FLUSH;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end else begin
                    prof   = P_STALL;
                    cnt_nx = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        state_nx = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                prof = P_FREEZE;
            end
            default: begin
                state_nx = RUN;
            end
        endcase

        if (!arst_n) begin
            prof = P_IDLE;
        end
    end

    // Flush keeps IF/ID writable so the NOP is actually loaded.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.pipe_freeze  = 1'b0;
        case (prof)
            P_STALL: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
            P_FLUSH: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end
            P_FREEZE: begin
                hz.pc_write    = 1'b0;
                hz.if_id_write = 1'b0;
                hz.pipe_freeze = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= RUN;
            ret    <= RUN;
            cnt    <= '0;
            perf_q <= '0;
        end else begin
            state <= state_nx;
            ret   <= ret_nx;
            cnt   <= cnt_nx;
            if (!hz.pc_write && perf_q != '1) begin
                perf_q <= perf_q + 1'b1;
            end
        end
    end

    assign hz.stall_cycles = perf_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Two instances share one stimulus:
// dut_a (LOAD_USE_STALL=1, PERF_W=32) and dut_b (LOAD_USE_STALL=3, PERF_W=4).
// The reference model tracks bubbles still owed and whether a memory wait is
// outstanding, rather than an explicit state machine.
module tb_hazard_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n;
    logic       mem_read, u1, u2, br, req, rdy;
    logic [4:0] rd, rs1, rs2;

    hazard_unit_if #(.REG_ADDR_W(5), .PERF_W(32)) ifa ();
    hazard_unit_if #(.REG_ADDR_W(5), .PERF_W(4))  ifb ();

    assign ifa.id_ex_mem_read  = mem_read;
    assign ifa.id_ex_rd        = rd;
    assign ifa.if_id_rs1       = rs1;
    assign ifa.if_id_rs2       = rs2;
    assign ifa.if_id_uses_rs1  = u1;
    assign ifa.if_id_uses_rs2  = u2;
    assign ifa.ex_branch_taken = br;
    assign ifa.mem_req         = req;
    assign ifa.mem_ready       = rdy;
    assign ifb.id_ex_mem_read  = mem_read;
    assign ifb.id_ex_rd        = rd;
    assign ifb.if_id_rs1       = rs1;
    assign ifb.if_id_rs2       = rs2;
    assign ifb.if_id_uses_rs1  = u1;
    assign ifb.if_id_uses_rs2  = u2;
    assign ifb.ex_branch_taken = br;
    assign ifb.mem_req         = req;
    assign ifb.mem_ready       = rdy;

    hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(1), .CNT_W(3), .PERF_W(32)) dut_a (
        .clk(clk), .arst_n(arst_n), .hz(ifa.slave));
    hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(3), .CNT_W(3), .PERF_W(4)) dut_b (
        .clk(clk), .arst_n(arst_n), .hz(ifb.slave));

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    localparam logic [4:0] V_IDLE   = 5'b11000;
    localparam logic [4:0] V_STALL  = 5'b00010;
    localparam logic [4:0] V_FLUSH  = 5'b11110;
    localparam logic [4:0] V_FREEZE = 5'b00001;

    int n_tests = 0;
    int n_fail  = 0;

    int     owed[2];
    bit     waiting[2];
    longint perf[2];
    int     lus[2]  = '{1, 3};
    longint pmax[2] = '{64'd4294967295, 64'd15};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] vec_a();
        return {ifa.pc_write, ifa.if_id_write, ifa.if_id_flush, ifa.id_ex_bubble, ifa.pipe_freeze};
    endfunction

    function automatic logic [4:0] vec_b();
        return {ifb.pc_write, ifb.if_id_write, ifb.if_id_flush, ifb.id_ex_bubble, ifb.pipe_freeze};
    endfunction

    // Profile codes: 0 idle, 1 stall, 2 flush, 3 freeze.
    task automatic model_eval(input int k, output int prof, output int nowed, output bit nwait);
        bit hit, blocked;
        hit = mem_read && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        nowed = owed[k];
        nwait = 1'b0;
        prof  = 0;
        if (!arst_n) begin
            nowed = 0;
        end else begin
            blocked = waiting[k] ? !rdy : (req && !rdy);
            if (blocked) begin
                prof  = 3;
                nwait = 1'b1;
            end else if (br) begin
                prof  = 2;
                nowed = 0;
            end else if (owed[k] > 0) begin
                prof  = 1;
                nowed = owed[k] - 1;
            end else if (hit) begin
                prof  = 1;
                nowed = lus[k] - 1;
            end
        end
    endtask

    function automatic logic [4:0] prof_vec(input int p);
        case (p)
            1:       return V_STALL;
            2:       return V_FLUSH;
            3:       return V_FREEZE;
            default: return V_IDLE;
        endcase
    endfunction

    // Entered at posedge+1, leaves at the next posedge+1.
    task automatic step(input string tag, input bit use_exp_b, input logic [4:0] exp_b);
        int p[2];
        int no[2];
        bit nw[2];
        #4;
        for (int k = 0; k < 2; k++) model_eval(k, p[k], no[k], nw[k]);
        check($sformatf("%s/a_ctl", tag), 64'(vec_a()), 64'(prof_vec(p[0])));
        check($sformatf("%s/b_ctl", tag), 64'(vec_b()), 64'(prof_vec(p[1])));
        if (use_exp_b) check($sformatf("%s/b_ctl_exp", tag), 64'(vec_b()), 64'(exp_b));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!arst_n) begin
                owed[k] = 0; waiting[k] = 1'b0; perf[k] = 0;
            end else begin
                owed[k]    = no[k];
                waiting[k] = nw[k];
                if ((p[k] == 1 || p[k] == 3) && perf[k] < pmax[k]) perf[k]++;
            end
        end
        #1;
        check($sformatf("%s/a_cnt", tag), 64'(ifa.stall_cycles), 64'(perf[0]));
        check($sformatf("%s/b_cnt", tag), 64'(ifb.stall_cycles), 64'(perf[1]));
    endtask

    task automatic clear_in();
        mem_read = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
        br = 0; req = 0; rdy = 0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        step("reset", 1'b1, V_IDLE);
        arst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] mexp[6];
        mexp = '{V_STALL, V_FREEZE, V_FREEZE, V_STALL, V_STALL, V_IDLE};
        for (int k = 0; k < 2; k++) begin owed[k] = 0; waiting[k] = 0; perf[k] = 0; end
        arst_n = 1'b0;
        clear_in();
        @(posedge clk); #1;
        do_reset();

        // Load-use with single bubble on dut_a.
        mem_read = 1; rd = 5; rs1 = 5; u1 = 1;
        #1 check("lu1_prof", 64'(vec_a()), 64'(V_STALL));
        step("lu1_hit", 1'b0, V_IDLE);
        clear_in();
        #1 check("lu1_idle", 64'(vec_a()), 64'(V_IDLE));
        check("lu1_cnt", 64'(ifa.stall_cycles), 64'd1);
        step("lu1_after", 1'b0, V_IDLE);
        step("lu1_after2", 1'b0, V_IDLE);
        step("lu1_after3", 1'b0, V_IDLE);

        // x0, unused operand, non-load.
        do_reset();
        mem_read = 1; rd = 0; rs1 = 0; u1 = 1;
        step("x0", 1'b1, V_IDLE);
        mem_read = 1; rd = 7; rs1 = 3; rs2 = 7; u1 = 1; u2 = 0;
        step("unused_rs2", 1'b1, V_IDLE);
        mem_read = 0; rd = 7; rs1 = 7; u1 = 1; u2 = 0;
        step("non_load", 1'b1, V_IDLE);

        // Multi-cycle stall interleaved with a memory wait.
        clear_in();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_in();
            if (c == 0) begin mem_read = 1; rd = 9; rs2 = 9; u2 = 1; end
            if (c == 1 || c == 2) begin req = 1; rdy = 0; end
            if (c == 3) begin rdy = 1; end
            step($sformatf("multi_c%0d", c), 1'b1, mexp[c]);
        end
        check("multi_total", 64'(ifb.stall_cycles), 64'd5);

        // Branch beats load-use.
        do_reset();
        mem_read = 1; rd = 4; rs1 = 4; u1 = 1; br = 1;
        step("br_vs_lu", 1'b1, V_FLUSH);
        clear_in();
        step("br_after", 1'b1, V_IDLE);

        // Memory wait holds a taken branch until mem_ready.
        do_reset();
        br = 1; req = 1; rdy = 0;
        for (int c = 0; c < 4; c++) step($sformatf("memwait_c%0d", c), 1'b1, V_FREEZE);
        rdy = 1;
        step("memwait_done", 1'b1, V_FLUSH);
        clear_in();
        step("memwait_after", 1'b1, V_IDLE);

        // Reset mid-stall: dut_b holds cnt=2 after the hit cycle.
        do_reset();
        mem_read = 1; rd = 6; rs1 = 6; u1 = 1;
        step("rst_hit", 1'b1, V_STALL);
        arst_n = 1'b0;
        #1 check("rst_immediate", 64'(vec_b()), 64'(V_IDLE));
        step("rst_low", 1'b1, V_IDLE);
        clear_in();
        arst_n = 1'b1;
        step("rst_release", 1'b1, V_IDLE);
        step("rst_release2", 1'b1, V_IDLE);

        // Counter saturation on the 4-bit counter.
        do_reset();
        mem_read = 1; rd = 2; rs2 = 2; u2 = 1;
        for (int c = 0; c < 20; c++) step("sat", 1'b1, V_STALL);
        check("sat_b", 64'(ifb.stall_cycles), 64'd15);
        check("sat_a", 64'(ifa.stall_cycles), 64'd20);
        clear_in();
        step("sat_after", 1'b0, V_IDLE);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            arst_n   = ($urandom_range(0, 99) != 0);
            mem_read = ($urandom_range(0, 1) == 1);
            rd       = 5'($urandom_range(0, 7));
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            u1       = ($urandom_range(0, 9) < 7);
            u2       = ($urandom_range(0, 9) < 7);
            br       = ($urandom_range(0, 9) == 0);
            req      = ($urandom_range(0, 9) < 3);
            rdy      = ($urandom_range(0, 9) < 6);
            step("rand", 1'b0, V_IDLE);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
